// File: rtl/hid_pkg.sv
// Shared types and helpers for the HID report scheduler.
package hid_pkg;

    localparam logic [1:0] TYP_NONE  = 2'd0;
    localparam logic [1:0] TYP_KBD   = 2'd1;
    localparam logic [1:0] TYP_MOUSE = 2'd2;
    localparam logic [1:0] TYP_GAME  = 2'd3;

    localparam int unsigned HID_PAY_W = 40;
    localparam int unsigned HID_REC_W = 42;

    typedef struct packed {
        logic [1:0]           typ;
        logic [HID_PAY_W-1:0] payload;
    } hid_rec_t;

    // Signed 8-bit add clamped to [-128, +127]
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {a[7], a} + {b[7], b};
        if (s[8] != s[7]) begin
            sat_add8 = s[8] ? 8'h80 : 8'h7F;
        end else begin
            sat_add8 = s[7:0];
        end
    endfunction

endpackage

// File: rtl/hid_rec_fifo.sv
// Record FIFO with registered fall-through head, synchronous flush and an
// in-place write port to the newest entry.
module hid_rec_fifo
    import hid_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    i_push,
    input  hid_rec_t                i_push_rec,
    input  logic                    i_pop,
    input  logic                    i_flush,
    input  logic                    i_upd,
    input  hid_rec_t                i_upd_rec,
    output logic                    o_valid,
    output hid_rec_t                o_rec,
    output hid_rec_t                o_newest,
    output logic                    o_full,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    hid_rec_t        r_mem [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_level;
    logic            r_valid;
    hid_rec_t        r_out;

    logic [PW-1:0]   w_wr_nxt;
    logic [PW-1:0]   w_rd_nxt;
    logic [AW-1:0]   w_newest_idx;

    // Next pointer values and newest-entry index
    always_comb begin
        w_wr_nxt     = r_wr + PW'(i_push);
        w_rd_nxt     = r_rd + PW'(i_pop);
        w_newest_idx = r_wr[AW-1:0] - AW'(1);
    end

    // Storage: append at tail, or rewrite newest entry on a merge
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr[AW-1:0]] <= i_push_rec;
        end else if (i_upd && !i_flush) begin
            r_mem[w_newest_idx] <= i_upd_rec;
        end
    end

    // Pointers and occupancy; flush empties the queue
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
            r_level <= w_wr_nxt - w_rd_nxt;
        end
    end

    // Head register: reflects entries present before this edge, so a push
    // into an empty queue shows up one cycle after it is written
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else begin
            r_valid <= (r_wr != w_rd_nxt);
            r_out   <= r_mem[w_rd_nxt[AW-1:0]];
        end
    end

    assign o_valid  = r_valid;
    assign o_rec    = r_out;
    assign o_newest = r_mem[w_newest_idx];
    assign o_full   = (r_level == PW'(DEPTH));
    assign o_level  = r_level;

endmodule

// File: rtl/hid_report_sched.sv
// HID report scheduler: packs usb_hid_host reports into typed records and
// queues them for a slow valid/ready consumer.
// Optional build macro HID_MOUSE_COALESCE_EN: fold mouse motion into the
// newest queued mouse record instead of dropping when the queue is full.
module hid_report_sched
    import hid_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [1:0]              usb_type,
    input  logic                    usb_report,
    input  logic                    usb_conerr,
    input  logic [7:0]              key_modifiers,
    input  logic [7:0]              key1,
    input  logic [7:0]              key2,
    input  logic [7:0]              key3,
    input  logic [7:0]              key4,
    input  logic [7:0]              mouse_btn,
    input  logic [7:0]              mouse_dx,
    input  logic [7:0]              mouse_dy,
    input  logic [9:0]              game_btns,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [HID_REC_W-1:0]    out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic [7:0]              drop_cnt
);

    hid_rec_t   w_in_rec;
    hid_rec_t   w_newest;
    hid_rec_t   w_upd_rec;
    hid_rec_t   w_head;
    logic       w_req;
    logic       w_pop;
    logic       w_full;
    logic       w_push;
    logic       w_merge;
    logic       w_drop;
    logic [7:0] r_drop;

    // Pack the strobed HID fields into a typed record
    always_comb begin
        w_in_rec.typ     = usb_type;
        w_in_rec.payload = '0;
        case (usb_type)
            TYP_KBD:   w_in_rec.payload = {key_modifiers, key1, key2, key3, key4};
            TYP_MOUSE: w_in_rec.payload = {16'h0, mouse_btn, mouse_dx, mouse_dy};
            TYP_GAME:  w_in_rec.payload = {30'h0, game_btns};
            default:   w_in_rec.payload = '0;
        endcase
    end

    // Newest entry with the incoming motion folded in
    always_comb begin
        w_upd_rec              = w_newest;
        w_upd_rec.payload[15:8] = sat_add8(w_newest.payload[15:8], mouse_dx);
        w_upd_rec.payload[7:0]  = sat_add8(w_newest.payload[7:0], mouse_dy);
    end

    // Push qualification, merge decision and drop detection
    always_comb begin
        w_req  = usb_report && (usb_type != TYP_NONE) && !usb_conerr;
        w_pop  = out_valid && out_ready && !usb_conerr;
        w_push = w_req && (!w_full || w_pop);
`ifdef HID_MOUSE_COALESCE_EN
        w_merge = w_req && w_full && !w_pop
                  && (usb_type == TYP_MOUSE)
                  && (w_newest.typ == TYP_MOUSE)
                  && (w_newest.payload[23:16] == mouse_btn);
`else
        w_merge = 1'b0;
`endif
        w_drop = w_req && w_full && !w_pop && !w_merge;
    end

    // Saturating count of discarded reports; survives flushes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    hid_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .i_push     (w_push),
        .i_push_rec (w_in_rec),
        .i_pop      (w_pop),
        .i_flush    (usb_conerr),
        .i_upd      (w_merge),
        .i_upd_rec  (w_upd_rec),
        .o_valid    (out_valid),
        .o_rec      (w_head),
        .o_newest   (w_newest),
        .o_full     (w_full),
        .o_level    (level)
    );

    assign out_data = w_head;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_hid_report_sched.sv
// Scoreboard bench for hid_report_sched (DEPTH=4).
module tb_hid_report_sched;
    import hid_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  usb_type;
    logic        usb_report;
    logic        usb_conerr;
    logic [7:0]  key_modifiers, key1, key2, key3, key4;
    logic [7:0]  mouse_btn, mouse_dx, mouse_dy;
    logic [9:0]  game_btns;
    logic        out_valid;
    logic        out_ready;
    logic [41:0] out_data;
    logic [2:0]  level;
    logic [7:0]  drop_cnt;

    hid_report_sched #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .usb_type      (usb_type),
        .usb_report    (usb_report),
        .usb_conerr    (usb_conerr),
        .key_modifiers (key_modifiers),
        .key1          (key1),
        .key2          (key2),
        .key3          (key3),
        .key4          (key4),
        .mouse_btn     (mouse_btn),
        .mouse_dx      (mouse_dx),
        .mouse_dy      (mouse_dy),
        .game_btns     (game_btns),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .level         (level),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_drop = 0;
    logic [41:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Compare every accepted record against the scoreboard
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("pop_unexpected", 64'(out_valid), 64'd0);
            else check("pop_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
    end

    function automatic logic [39:0] mpay(input logic [7:0] b, input logic [7:0] dx, input logic [7:0] dy);
        return {16'h0, b, dx, dy};
    endfunction

    function automatic logic [39:0] gpay(input logic [9:0] g);
        return {30'h0, g};
    endfunction

    task automatic bump_drop();
        if (exp_drop < 255) exp_drop++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle report strobe; expected record queued when it should be accepted
    task automatic rpt(input logic [1:0] t, input logic [39:0] pay, input bit acc);
        usb_type      = t;
        key_modifiers = pay[39:32];
        key1          = pay[31:24];
        key2          = pay[23:16];
        key3          = pay[15:8];
        key4          = pay[7:0];
        mouse_btn     = pay[23:16];
        mouse_dx      = pay[15:8];
        mouse_dy      = pay[7:0];
        game_btns     = pay[9:0];
        usb_report    = 1'b1;
        if (acc) exp_q.push_back({t, pay});
        @(posedge clk);
        #1;
        usb_report = 1'b0;
        usb_type   = TYP_NONE;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
        tick(2);
        check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_level"}, 64'(level), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; usb_type = TYP_NONE; usb_report = 1'b0; usb_conerr = 1'b0;
        key_modifiers = '0; key1 = '0; key2 = '0; key3 = '0; key4 = '0;
        mouse_btn = '0; mouse_dx = '0; mouse_dy = '0; game_btns = '0;
        out_ready = 1'b0;
        tick(3);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        resetn = 1'b1;
        tick(1);

        // T1: keyboard record, type-0 pulse ignored
        out_ready = 1'b1;
        rpt(TYP_NONE, 40'h1122334455, 1'b0);
        check("t1_type0_level", 64'(level), 64'd0);
        rpt(TYP_KBD, 40'h0204000000, 1'b1);
        check("t1_level_pushed", 64'(level), 64'd1);
        check("t1_no_bypass", 64'(out_valid), 64'd0);
        tick(1);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'({2'd1, 40'h0204000000}));
        tick(1);
        check("t1_level_back", 64'(level), 64'd0);
        check("t1_valid_low", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // T2: overflow drops, order preserved
        for (int i = 1; i <= 6; i++) begin
            rpt(TYP_MOUSE, mpay(8'(i), 8'(i * 3), 8'(-i)), (i <= 4));
            if (i > 4) bump_drop();
        end
        tick(1);
        check("t2_level_full", 64'(level), 64'd4);
        check("t2_drop", 64'(drop_cnt), 64'(exp_drop));
        check("t2_head", 64'(out_data), 64'(exp_q[0]));
        drain("t2");

        // T3: full queue with matching mouse newest entry
        rpt(TYP_GAME, gpay(10'h201), 1'b1);
        rpt(TYP_GAME, gpay(10'h102), 1'b1);
        rpt(TYP_KBD, 40'h00_2C_00_00_00, 1'b1);
        rpt(TYP_MOUSE, mpay(8'd1, 8'd100, 8'd10), 1'b1);
`ifdef HID_MOUSE_COALESCE_EN
        rpt(TYP_MOUSE, mpay(8'd1, 8'd50, 8'hFD), 1'b0);
        exp_q[exp_q.size() - 1] = {TYP_MOUSE, mpay(8'd1, 8'h7F, 8'd7)};
`else
        rpt(TYP_MOUSE, mpay(8'd1, 8'd50, 8'hFD), 1'b0);
        bump_drop();
`endif
        check("t3_level", 64'(level), 64'd4);
        check("t3_drop", 64'(drop_cnt), 64'(exp_drop));
        rpt(TYP_MOUSE, mpay(8'd2, 8'd1, 8'd1), 1'b0);
        bump_drop();
        check("t3_drop_btn_mismatch", 64'(drop_cnt), 64'(exp_drop));
        drain("t3");

        // T4: full, push and pop in the same cycle
        for (int i = 0; i < 4; i++) rpt(TYP_GAME, gpay(10'(i + 16)), 1'b1);
        tick(1);
        check("t4_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        rpt(TYP_KBD, 40'hE11A1B1C1D, 1'b1);
        out_ready = 1'b0;
        check("t4_level", 64'(level), 64'd4);
        check("t4_drop", 64'(drop_cnt), 64'(exp_drop));
        drain("t4");

        // T5: connection error flushes and blocks pushes
        for (int i = 0; i < 3; i++) rpt(TYP_MOUSE, mpay(8'(i + 8), 8'd0, 8'd0), 1'b1);
        tick(1);
        check("t5_level_pre", 64'(level), 64'd3);
        usb_conerr = 1'b1;
        rpt(TYP_GAME, gpay(10'h3FF), 1'b0);
        exp_q.delete();
        check("t5_valid_flushed", 64'(out_valid), 64'd0);
        check("t5_level_flushed", 64'(level), 64'd0);
        check("t5_drop_kept", 64'(drop_cnt), 64'(exp_drop));
        rpt(TYP_KBD, 40'h0104000000, 1'b0);
        check("t5_level_blocked", 64'(level), 64'd0);
        usb_conerr = 1'b0;
        tick(1);
        check("t5_valid_after", 64'(out_valid), 64'd0);
        rpt(TYP_KBD, 40'h0005000000, 1'b1);
        drain("t5");

        // T6: async reset mid-handshake
        rpt(TYP_KBD, 40'h0006000000, 1'b1);
        rpt(TYP_KBD, 40'h0007000000, 1'b1);
        tick(1);
        check("t6_valid_pre", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_data", 64'(out_data), 64'd0);
        check("t6_level", 64'(level), 64'd0);
        check("t6_drop", 64'(drop_cnt), 64'd0);
        exp_q.delete();
        exp_drop  = 0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick(1);
        rpt(TYP_GAME, gpay(10'h2AA), 1'b1);
        drain("t6");

        // T7: drop counter saturates
        for (int i = 0; i < 4; i++) rpt(TYP_KBD, {8'(i), 32'h0}, 1'b1);
        for (int i = 0; i < 260; i++) begin
            rpt(TYP_GAME, gpay(10'(i)), 1'b0);
            bump_drop();
            if (i == 254) check("t7_drop_255", 64'(drop_cnt), 64'(exp_drop));
        end
        check("t7_drop_sat", 64'(drop_cnt), 64'(exp_drop));
        check("t7_level", 64'(level), 64'd4);
        drain("t7");
        check("t7_drop_hold", 64'(drop_cnt), 64'(exp_drop));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
